point_stepper: RTL and testbench

//  Consumer end of the line-generator point stream. Buffers (x,y) points qualified by a valid pulse.

---
 rtl/motion_pkg.sv | 12 +
 rtl/point_fifo.sv | 43 ++++
 rtl/point_stepper.sv | 168 ++++++++++++++++
 tb/tb_point_stepper.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/motion_pkg.sv
// motion_pkg: shared FSM state encoding and direction constants for point_stepper
package motion_pkg;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_DIR_SETUP = 3'd2,
    S_PULSE_HI  = 3'd3,
    S_PULSE_LO  = 3'd4
  } state_e;
  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;
endpackage

// File: rtl/point_fifo.sv
// point_fifo: synchronous point FIFO, registered read data valid the cycle after pop
module point_fifo #(
  parameter int P_W  = 22,
  parameter int P_AW = 3
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  input  logic           i_push,
  input  logic           i_pop,
  input  logic [P_W-1:0] i_data,
  output logic [P_W-1:0] o_data,
  output logic           o_full,
  output logic           o_empty
);
  logic [P_W-1:0]  mem_q [2**P_AW];
  logic [P_W-1:0]  data_q;
  logic [P_AW-1:0] wr_q, rd_q;
  logic [P_AW:0]   cnt_q;
  logic            do_push, do_pop;
  assign o_full  = cnt_q[P_AW];
  assign o_empty = cnt_q == '0;
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);
  assign o_data  = data_q;
  // storage array, written only on an accepted push
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_q] <= i_data;
  end
  // pointers, occupancy and the registered read port
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      wr_q  <= wr_q + P_AW'(do_push);
      rd_q  <= rd_q + P_AW'(do_pop);
      cnt_q <= cnt_q + (P_AW+1)'(do_push) - (P_AW+1)'(do_pop);
      if (do_pop) data_q <= mem_q[rd_q];
    end
  end
endmodule

// File: rtl/point_stepper.sv
// point_stepper: turns buffered (x,y) points into step/dir pulses; POINT_STEPPER_POS_OUT_EN exposes position
module point_stepper
  import motion_pkg::*;
#(
  parameter int P_X_COORD_W = 11,
  parameter int P_Y_COORD_W = 11,
  parameter int P_FIFO_AW   = 3,
  parameter int P_TIMER_W   = 16,
  parameter int P_DIR_SETUP = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [P_X_COORD_W-1:0] i_x_val,
  input  logic [P_Y_COORD_W-1:0] i_y_val,
  input  logic                   i_vals_rdy,
  input  logic [P_TIMER_W-1:0]   i_pulse_cycles,
  input  logic [P_TIMER_W-1:0]   i_period_cycles,
  input  logic                   i_resync,
  input  logic                   i_clr_overflow,
  output logic                   o_step_x,
  output logic                   o_step_y,
  output logic                   o_dir_x,
  output logic                   o_dir_y,
  output logic                   o_fifo_full,
  output logic                   o_overflow,
`ifdef POINT_STEPPER_POS_OUT_EN
  output logic [P_X_COORD_W-1:0] o_pos_x,
  output logic [P_Y_COORD_W-1:0] o_pos_y,
`endif
  output logic                   o_idle
);
  localparam int FW = P_X_COORD_W + P_Y_COORD_W;
  state_e                        state_q, state_d;
  logic [P_TIMER_W-1:0]          tmr_q, tmr_d, hi_q, hi_d, hi_n, lo_n;
  logic [P_X_COORD_W-1:0]        rem_x_q, rem_x_d, pos_x_q, pos_x_d, pt_x, rem_x_n;
  logic [P_Y_COORD_W-1:0]        rem_y_q, rem_y_d, pos_y_q, pos_y_d, pt_y, rem_y_n;
  logic                          pos_valid_q, pos_valid_d, resync_q, resync_d;
  logic                          dir_x_q, dir_x_d, dir_y_q, dir_y_d, ovf_q, ovf_d;
  logic                          dir_x_n, dir_y_n, pop, fifo_empty;
  logic [FW-1:0]                 fifo_data;
  logic signed [P_X_COORD_W:0]   dx;
  logic signed [P_Y_COORD_W:0]   dy;
  point_fifo #(.P_W(FW), .P_AW(P_FIFO_AW)) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (i_vals_rdy),
    .i_pop     (pop),
    .i_data    ({i_x_val, i_y_val}),
    .o_data    (fifo_data),
    .o_full    (o_fifo_full),
    .o_empty   (fifo_empty)
  );
  assign pt_x    = fifo_data[FW-1:P_Y_COORD_W];
  assign pt_y    = fifo_data[P_Y_COORD_W-1:0];
  assign dx      = $signed({1'b0, pt_x}) - $signed({1'b0, pos_x_q});
  assign dy      = $signed({1'b0, pt_y}) - $signed({1'b0, pos_y_q});
  assign rem_x_n = P_X_COORD_W'(dx[P_X_COORD_W] ? -dx : dx);
  assign rem_y_n = P_Y_COORD_W'(dy[P_Y_COORD_W] ? -dy : dy);
  assign dir_x_n = !dx[P_X_COORD_W] && dx != '0;
  assign dir_y_n = !dy[P_Y_COORD_W] && dy != '0;
  assign hi_n    = (i_pulse_cycles == '0) ? P_TIMER_W'(1) : i_pulse_cycles;
  assign lo_n    = (i_period_cycles > hi_q) ? i_period_cycles - hi_q : P_TIMER_W'(1);
  assign ovf_d   = (i_vals_rdy && o_fifo_full && !pop) ? 1'b1 : i_clr_overflow ? 1'b0 : ovf_q;
  assign o_step_x   = state_q == S_PULSE_HI && rem_x_q != '0;
  assign o_step_y   = state_q == S_PULSE_HI && rem_y_q != '0;
  assign o_dir_x    = dir_x_q;
  assign o_dir_y    = dir_y_q;
  assign o_overflow = ovf_q;
  assign o_idle     = fifo_empty && state_q == S_IDLE;
`ifdef POINT_STEPPER_POS_OUT_EN
  assign o_pos_x = pos_x_q;
  assign o_pos_y = pos_y_q;
`endif
  // move sequencing: pop, load/resync, dir setup, then timed high/low pulse pairs
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    hi_d        = hi_q;
    rem_x_d     = rem_x_q;
    rem_y_d     = rem_y_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    pos_valid_d = pos_valid_q;
    resync_d    = resync_q | i_resync;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: if (!fifo_empty) begin
        pop     = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: if (!pos_valid_q || resync_q) begin
        pos_x_d     = pt_x;
        pos_y_d     = pt_y;
        pos_valid_d = 1'b1;
        resync_d    = i_resync;
        state_d     = S_IDLE;
      end else if (dx == '0 && dy == '0) begin
        state_d = S_IDLE;
      end else begin
        rem_x_d = rem_x_n;
        rem_y_d = rem_y_n;
        dir_x_d = dir_x_n;
        dir_y_d = dir_y_n;
        if (dir_x_n != dir_x_q || dir_y_n != dir_y_q) begin
          state_d = S_DIR_SETUP;
          tmr_d   = P_TIMER_W'(P_DIR_SETUP - 1);
        end else begin
          state_d = S_PULSE_HI;
          hi_d    = hi_n;
          tmr_d   = hi_n - P_TIMER_W'(1);
        end
      end
      S_DIR_SETUP: if (tmr_q == '0) begin
        state_d = S_PULSE_HI;
        hi_d    = hi_n;
        tmr_d   = hi_n - P_TIMER_W'(1);
      end else tmr_d = tmr_q - P_TIMER_W'(1);
      S_PULSE_HI: if (tmr_q == '0) begin
        rem_x_d = rem_x_q - P_X_COORD_W'(rem_x_q != '0);
        rem_y_d = rem_y_q - P_Y_COORD_W'(rem_y_q != '0);
        pos_x_d = (rem_x_q == '0) ? pos_x_q : (dir_x_q == DIR_POS) ? pos_x_q + P_X_COORD_W'(1) : pos_x_q - P_X_COORD_W'(1);
        pos_y_d = (rem_y_q == '0) ? pos_y_q : (dir_y_q == DIR_POS) ? pos_y_q + P_Y_COORD_W'(1) : pos_y_q - P_Y_COORD_W'(1);
        state_d = S_PULSE_LO;
        tmr_d   = lo_n - P_TIMER_W'(1);
      end else tmr_d = tmr_q - P_TIMER_W'(1);
      S_PULSE_LO: if (tmr_q != '0) begin
        tmr_d = tmr_q - P_TIMER_W'(1);
      end else if (rem_x_q != '0 || rem_y_q != '0) begin
        state_d = S_PULSE_HI;
        hi_d    = hi_n;
        tmr_d   = hi_n - P_TIMER_W'(1);
      end else state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // state, timers, position and sticky flags
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      hi_q        <= P_TIMER_W'(1);
      rem_x_q     <= '0;
      rem_y_q     <= '0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      pos_valid_q <= 1'b0;
      resync_q    <= 1'b0;
      dir_x_q     <= DIR_NEG;
      dir_y_q     <= DIR_NEG;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      hi_q        <= hi_d;
      rem_x_q     <= rem_x_d;
      rem_y_q     <= rem_y_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      pos_valid_q <= pos_valid_d;
      resync_q    <= resync_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      ovf_q       <= ovf_d;
    end
  end
endmodule

// File: tb/tb_point_stepper.sv
// tb_point_stepper: directed checks of point_stepper pulse timing, direction setup, FIFO overflow, reset and resync
module tb_point_stepper;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic [10:0] x_val = '0, y_val = '0;
  logic        vals_rdy = 1'b0, resync = 1'b0, clr_ovf = 1'b0;
  logic [15:0] pulse = 16'd2, period = 16'd5;
  logic        step_x, step_y, dir_x, dir_y, fifo_full, overflow, idle;
  logic [10:0] pos_x, pos_y;
  int n_cmp = 0, n_err = 0, cyc = 0, dxc = 0;
  int xr[$], xf[$], yr[$], yf[$];
  logic px = 1'b0, py = 1'b0, pdx = 1'b0;

  point_stepper dut (
    .i_clk           (clk),
    .i_reset_n       (reset_n),
    .i_x_val         (x_val),
    .i_y_val         (y_val),
    .i_vals_rdy      (vals_rdy),
    .i_pulse_cycles  (pulse),
    .i_period_cycles (period),
    .i_resync        (resync),
    .i_clr_overflow  (clr_ovf),
    .o_step_x        (step_x),
    .o_step_y        (step_y),
    .o_dir_x         (dir_x),
    .o_dir_y         (dir_y),
    .o_fifo_full     (fifo_full),
    .o_overflow      (overflow),
`ifdef POINT_STEPPER_POS_OUT_EN
    .o_pos_x         (pos_x),
    .o_pos_y         (pos_y),
`endif
    .o_idle          (idle)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (step_x && !px) xr.push_back(cyc);
    if (!step_x && px) xf.push_back(cyc);
    if (step_y && !py) yr.push_back(cyc);
    if (!step_y && py) yf.push_back(cyc);
    if (dir_x !== pdx) dxc = cyc;
    px  = step_x;
    py  = step_y;
    pdx = dir_x;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    xr.delete(); xf.delete(); yr.delete(); yf.delete();
  endtask

  task automatic push_pt(input int x, input int y);
    x_val    = 11'(x);
    y_val    = 11'(y);
    vals_rdy = 1'b1;
    @(negedge clk);
    vals_rdy = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!idle && n < 3000);
    if (!idle) check(tag, 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_resync();
    resync = 1'b1;
    @(negedge clk);
    resync = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_step_x", step_x, 0);
    check("rst_step_y", step_y, 0);
    check("rst_dir_x", dir_x, 0);
    check("rst_full", fifo_full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_idle", idle, 1);
    reset_n = 1'b1;
    @(negedge clk);
    // first point only sets position, then a 3x1 move
    clr_mon();
    push_pt(10, 10);
    wait_idle("t1a_timeout");
    check("t1_first_no_steps", xr.size() + yr.size(), 0);
    push_pt(13, 11);
    wait_idle("t1b_timeout");
    check("t1_x_pulses", xr.size(), 3);
    check("t1_y_pulses", yr.size(), 1);
    if (xr.size() == 3 && xf.size() >= 1 && yr.size() >= 1) begin
      check("t1_x_period1", xr[1] - xr[0], 5);
      check("t1_x_period2", xr[2] - xr[1], 5);
      check("t1_x_high", xf[0] - xr[0], 2);
      check("t1_y_with_x", yr[0], xr[0]);
    end else check("t1_pulse_records", 0, 1);
    check("t1_dir_x", dir_x, 1);
    check("t1_dir_y", dir_y, 1);
    // resync to (5,5), then a negative X move with direction setup
    pulse_resync();
    push_pt(5, 5);
    wait_idle("t2a_timeout");
    clr_mon();
    push_pt(2, 5);
    wait_idle("t2b_timeout");
    check("t2_x_pulses", xr.size(), 3);
    check("t2_y_pulses", yr.size(), 0);
    check("t2_dir_x", dir_x, 0);
    if (xr.size() >= 1) check("t2_dir_setup", xr[0] - dxc, 4);
    else check("t2_dir_setup_missing", 0, 1);
    // zero timing values give a 1-high 1-low pulse
    pulse = 16'd0; period = 16'd0;
    clr_mon();
    push_pt(4, 5);
    wait_idle("t4_timeout");
    check("t4_x_pulses", xr.size(), 2);
    if (xr.size() == 2 && xf.size() >= 1) begin
      check("t4_period", xr[1] - xr[0], 2);
      check("t4_high", xf[0] - xr[0], 1);
    end else check("t4_pulse_records", 0, 1);
    // overflow while busy on a long move
    pulse = 16'd1; period = 16'd2;
    clr_mon();
    push_pt(200, 5);
    repeat (5) @(negedge clk);
    for (int i = 1; i <= 9; i++) push_pt(200 + i, 5);
    check("t3_full", fifo_full, 1);
    check("t3_ovf", overflow, 1);
    x_val = 11'd210; vals_rdy = 1'b1; clr_ovf = 1'b1;
    @(negedge clk);
    vals_rdy = 1'b0;
    check("t3_ovf_wins", overflow, 1);
    @(negedge clk);
    clr_ovf = 1'b0;
    check("t3_ovf_cleared", overflow, 0);
    wait_idle("t3_timeout");
    check("t3_x_pulses", xr.size(), 204);
    check("t3_y_pulses", yr.size(), 0);
    check("t3_full_after", fifo_full, 0);
`ifdef POINT_STEPPER_POS_OUT_EN
    check("t3_pos_x", pos_x, 208);
`endif
    // reset in the middle of a high pulse
    pulse = 16'd4; period = 16'd8;
    push_pt(213, 5);
    begin
      int n = 0;
      while (!step_x && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("t5_saw_step", step_x, 1);
    end
    reset_n = 1'b0;
    @(negedge clk);
    check("t5_step_low", step_x, 0);
    check("t5_idle", idle, 1);
    reset_n = 1'b1;
    @(negedge clk);
    clr_mon();
    push_pt(50, 50);
    wait_idle("t5_timeout");
    check("t5_no_steps", xr.size() + yr.size(), 0);
    // repeated point and resync produce no steps
    push_pt(50, 50);
    wait_idle("t6a_timeout");
    pulse_resync();
    push_pt(100, 0);
    wait_idle("t6b_timeout");
    check("t6_no_steps", xr.size() + yr.size(), 0);
`ifdef POINT_STEPPER_POS_OUT_EN
    check("t6_pos_x", pos_x, 100);
    check("t6_pos_y", pos_y, 0);
`endif
    push_pt(101, 0);
    wait_idle("t6c_timeout");
    check("t6_one_x", xr.size(), 1);
    check("t6_no_y", yr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
